ltc2308_responder: RTL and testbench

- Synthesizable SPI responder that models the external 8-channel 12-bit LTC2308-style ADC at the far end of the adc_signals interface.
- Watches adc_convst, adc_sck and adc_sdi from the ADC controller, captures the 6-bit SDI config word, and shifts a 12-bit sample out on adc_sdo MSB-first.
- Sample values come from a parallel stimulus port, either a testbench or an on-chip pattern source.
- Used for closed-loop board and sim checks of the breakout system without the physical ADC.

---
 rtl/ltc2308_pkg.sv | 27 ++
 rtl/ltc2308_responder_sync_edge_det.sv | 31 +++
 rtl/ltc2308_responder.sv | 191 +++++++++++++++++++
 tb/tb_ltc2308_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ltc2308_pkg.sv
// Shared types and constants for the LTC2308-style SPI responder model.
// Config word layout, MSB first: S/D, O/S, S1, S0, UNI, SLP.
package ltc2308_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHIFT   = 2'd2,
    SLEEP   = 2'd3
  } state_t;

  localparam int CFG_W = 6;

  localparam logic [CFG_W-1:0] CFG_RESET = 6'b100010;

  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  function automatic logic [2:0] chan_of(input logic [CFG_W-1:0] cfg);
    return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
  endfunction

endpackage

// File: rtl/ltc2308_responder_sync_edge_det.sv
// Multi-stage synchronizer for one asynchronous pin, followed by a single
// history flop that turns level changes into one-cycle rise/fall pulses.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~dly_q;
  assign fall  = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/ltc2308_responder.sv
// Behavioural stand-in for an external LTC2308 ADC: answers convst/sck/sdi
// from the controller, returns sample_data on sdo and captures config words.
//
// state   | meaning
// IDLE    | out of reset, waiting for the first convst rise
// CONVERT | conversion timer running, busy high, sck edges are errors
// SHIFT   | sample on sdo, config on sdi; holds after the frame completes
// SLEEP   | SLP config swallowed one convst; next rise converts
module ltc2308_responder
  import ltc2308_pkg::*;
#(
  parameter int CONV_CYCLES = 80,
  parameter int DATA_BITS   = 12,
  parameter int CFG_BITS    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic                 adc_convst,
  input  logic                 adc_sck,
  input  logic                 adc_sdi,
  output logic                 adc_sdo,
  input  logic [DATA_BITS-1:0] sample_data,
  output logic [2:0]           sample_chan,
  output logic                 sample_req,
  output logic [CFG_BITS-1:0]  cfg_word,
  output logic                 cfg_valid,
  output logic                 busy,
  output logic                 proto_err
);

  localparam int CNT_W = $clog2(CONV_CYCLES);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] CFG_TAKE = BIT_W'(CFG_BITS);

  logic conv_lvl, conv_rise, conv_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic unused_sigs;

  state_t state_q, state_nxt;

  logic [CNT_W-1:0]     conv_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] tx_sr_q;
  logic [CFG_BITS-1:0]  rx_sr_q;
  logic [CFG_BITS-1:0]  cfg_q;
  logic [2:0]           chan_q;
  logic                 sample_req_q, cfg_valid_q, proto_err_q;

  logic start_conv, load_tx, bit_rise, shift_tx, cfg_done, err;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_convst (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .din   (adc_convst),
    .level (conv_lvl),
    .rise  (conv_rise),
    .fall  (conv_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .din   (adc_sck),
    .level (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .din   (adc_sdi),
    .level (sdi_lvl),
    .rise  (sdi_rise),
    .fall  (sdi_fall)
  );

  assign unused_sigs = &{1'b0, conv_lvl, conv_fall, sck_lvl, sdi_rise, sdi_fall};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_nxt;
  end

  always_comb begin
    state_nxt  = state_q;
    start_conv = 1'b0;
    load_tx    = 1'b0;
    bit_rise   = 1'b0;
    shift_tx   = 1'b0;
    cfg_done   = 1'b0;
    err        = 1'b0;
    case (state_q)
      IDLE: begin
        if (conv_rise) begin
          start_conv = 1'b1;
          state_nxt  = CONVERT;
        end
      end
      CONVERT: begin
        if (sck_rise || sck_fall) err = 1'b1;
        if (conv_cnt_q == '0) begin
          load_tx   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // convst takes priority; an sck edge in the same cycle is dropped
        if (conv_rise) begin
          if (bit_cnt_q != BIT_FULL) begin
            err        = 1'b1;
            start_conv = 1'b1;
            state_nxt  = CONVERT;
          end else if (cfg_q[CFG_SLP]) begin
            state_nxt = SLEEP;
          end else begin
            start_conv = 1'b1;
            state_nxt  = CONVERT;
          end
        end else begin
          if (sck_rise && (bit_cnt_q != BIT_FULL)) begin
            bit_rise = 1'b1;
            if (bit_cnt_q == BIT_LAST) cfg_done = 1'b1;
          end
          if (sck_fall) shift_tx = 1'b1;
        end
      end
      SLEEP: begin
        if (conv_rise) begin
          start_conv = 1'b1;
          state_nxt  = CONVERT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      conv_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      cfg_q        <= CFG_RESET;
      chan_q       <= 3'd0;
      sample_req_q <= 1'b0;
      cfg_valid_q  <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      sample_req_q <= start_conv;
      cfg_valid_q  <= cfg_done;
      proto_err_q  <= err;

      if (start_conv) begin
        conv_cnt_q <= CNT_LOAD;
        chan_q     <= chan_of(cfg_q);
        bit_cnt_q  <= '0;
        rx_sr_q    <= '0;
      end else if ((state_q == CONVERT) && (conv_cnt_q != '0)) begin
        conv_cnt_q <= conv_cnt_q - CNT_W'(1);
      end

      if (start_conv || (state_nxt == SLEEP)) tx_sr_q <= '0;
      else if (load_tx)                       tx_sr_q <= sample_data;
      else if (shift_tx)                      tx_sr_q <= tx_sr_q << 1;

      if (bit_rise) begin
        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q < CFG_TAKE) rx_sr_q <= {rx_sr_q[CFG_BITS-2:0], sdi_lvl};
      end

      // the received word only steers the following conversion
      if (cfg_done) cfg_q <= rx_sr_q;
    end
  end

  assign adc_sdo     = tx_sr_q[DATA_BITS-1];
  assign sample_chan = chan_q;
  assign sample_req  = sample_req_q;
  assign cfg_word    = cfg_q;
  assign cfg_valid   = cfg_valid_q;
  assign busy        = (state_q == CONVERT);
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_ltc2308_responder.sv
// Directed bench for ltc2308_responder: drives a slow SPI controller and
// checks returned samples, channel pipelining, errors, sleep and reset.
module tb_ltc2308_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        convst = 1'b0;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic        sdo;
  logic [11:0] sample_data = '0;
  logic [2:0]  sample_chan;
  logic        sample_req;
  logic [5:0]  cfg_word;
  logic        cfg_valid;
  logic        busy;
  logic        proto_err;

  int total = 0;
  int bad = 0;

  int n_req = 0, n_busy = 0, n_err = 0, n_cfgv = 0;
  logic [2:0] last_chan = '0;
  logic [5:0] last_cfg  = '0;
  int req0, busy0, err0, cfgv0;

  logic [11:0] rd;
  logic [2:0]  exp_chan;

  localparam logic [11:0] DATA_TBL [8] = '{12'h123, 12'hFFF, 12'h000, 12'h801,
                                          12'h7FE, 12'h5A5, 12'hC3C, 12'h069};
  localparam logic [5:0]  CFG_TBL  [8] = '{6'b100010, 6'b110010, 6'b100110, 6'b110110,
                                          6'b101010, 6'b111010, 6'b101110, 6'b111110};

  ltc2308_responder dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .adc_convst    (convst),
    .adc_sck       (sck),
    .adc_sdi       (sdi),
    .adc_sdo       (sdo),
    .sample_data   (sample_data),
    .sample_chan   (sample_chan),
    .sample_req    (sample_req),
    .cfg_word      (cfg_word),
    .cfg_valid     (cfg_valid),
    .busy          (busy),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sample_req) begin
      n_req     <= n_req + 1;
      last_chan <= sample_chan;
    end
    if (busy)      n_busy <= n_busy + 1;
    if (proto_err) n_err  <= n_err + 1;
    if (cfg_valid) begin
      n_cfgv   <= n_cfgv + 1;
      last_cfg <= cfg_word;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    req0  = n_req;
    busy0 = n_busy;
    err0  = n_err;
    cfgv0 = n_cfgv;
  endtask

  task automatic pulse_convst();
    tick(1);
    convst = 1'b1;
    tick(3);
    convst = 1'b0;
  endtask

  task automatic spi_frame(input logic [5:0] cfg, input int nclk, output logic [11:0] data);
    data = '0;
    for (int i = 0; i < nclk; i++) begin
      sdi = (i < 6) ? cfg[5-i] : 1'b0;
      tick(4);
      if (i < 12) data[11-i] = sdo;
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
    sdi = 1'b0;
    tick(4);
  endtask

  initial begin
    // reset values
    tick(3);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg", 32'(cfg_word), 32'h22);
    chk("rst_chan", 32'(sample_chan), 32'd0);
    chk("rst_req", 32'(sample_req), 32'd0);
    chk("rst_err", 32'(proto_err), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // first conversion on CH0, config for CH1 during the read
    sample_data = 12'hA5C;
    snap();
    pulse_convst();
    tick(100);
    chk("c1_req", 32'(n_req - req0), 32'd1);
    chk("c1_chan", 32'(last_chan), 32'd0);
    chk("c1_busy", 32'(n_busy - busy0), 32'd80);
    spi_frame(6'b110010, 12, rd);
    chk("c1_data", 32'(rd), 32'hA5C);
    chk("c1_sdo_end", 32'(sdo), 32'd0);
    chk("c1_cfgv", 32'(n_cfgv - cfgv0), 32'd1);
    chk("c1_cfgv_word", 32'(last_cfg), 32'b110010);
    chk("c1_cfg", 32'(cfg_word), 32'b110010);

    // back-to-back frames through all single-ended codes
    exp_chan = 3'd1;
    for (int k = 0; k < 8; k++) begin
      sample_data = DATA_TBL[k];
      snap();
      pulse_convst();
      tick(100);
      chk("b2b_chan", 32'(last_chan), 32'(exp_chan));
      spi_frame(CFG_TBL[k], 12, rd);
      chk("b2b_data", 32'(rd), 32'(DATA_TBL[k]));
      exp_chan = 3'(k);
    end
    chk("b2b_cfg", 32'(cfg_word), 32'b111110);

    // abort after 5 sck clocks, then sck during CONVERT
    sample_data = 12'h5A3;
    pulse_convst();
    tick(100);
    spi_frame(6'b100010, 5, rd);
    chk("ab_part", 32'(rd[11:7]), 32'b01011);
    sample_data = 12'hC3E;
    snap();
    pulse_convst();
    tick(6);
    chk("ab_err", 32'(n_err - err0), 32'd1);
    chk("ab_req", 32'(n_req - req0), 32'd1);
    chk("ab_chan", 32'(last_chan), 32'd7);
    chk("ab_cfg", 32'(cfg_word), 32'b111110);
    snap();
    for (int j = 0; j < 2; j++) begin
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
      tick(4);
    end
    tick(80);
    chk("cv_err", 32'(n_err - err0), 32'd4);
    spi_frame(6'b100011, 12, rd);
    chk("cv_data", 32'(rd), 32'hC3E);
    chk("cv_cfg", 32'(cfg_word), 32'b100011);

    // sleep: first convst swallowed, second converts
    sample_data = 12'h9B6;
    snap();
    pulse_convst();
    tick(100);
    chk("slp_req", 32'(n_req - req0), 32'd0);
    chk("slp_busy", 32'(n_busy - busy0), 32'd0);
    chk("slp_sdo", 32'(sdo), 32'd0);
    snap();
    pulse_convst();
    tick(100);
    chk("wake_req", 32'(n_req - req0), 32'd1);
    chk("wake_chan", 32'(last_chan), 32'd0);
    chk("wake_busy", 32'(n_busy - busy0), 32'd80);
    spi_frame(6'b110010, 12, rd);
    chk("wake_data", 32'(rd), 32'h9B6);

    // reset in the middle of a frame
    sample_data = 12'hA5C;
    pulse_convst();
    tick(100);
    spi_frame(6'b111010, 7, rd);
    chk("mid_part", 32'(rd[11:5]), 32'b1010010);
    chk("mid_sdo", 32'(sdo), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("mrst_sdo", 32'(sdo), 32'd0);
    chk("mrst_cfg", 32'(cfg_word), 32'b100010);
    chk("mrst_busy", 32'(busy), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    sample_data = 12'h3C7;
    snap();
    pulse_convst();
    tick(100);
    chk("pr_req", 32'(n_req - req0), 32'd1);
    chk("pr_chan", 32'(last_chan), 32'd0);
    chk("pr_busy", 32'(n_busy - busy0), 32'd80);
    spi_frame(6'b101010, 12, rd);
    chk("pr_data", 32'(rd), 32'h3C7);
    chk("pr_cfg", 32'(cfg_word), 32'b101010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
